ram_access_ctrl: RTL
====================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, core/RAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data word width (MEM_BUS); fixed at 32 for this revision.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_i  input  1  core access request, sampled only when ready_o=1.
REQ-006 SHALL have port we_i  input  1  1=store, 0=load.
REQ-007 SHALL have port size_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port unsigned_i  input  1  load zero-extend (1) / sign-extend (0).
REQ-009 SHALL have port addr_i  input  ADDR_W  byte address.
REQ-010 SHALL have port wdata_i  input  DATA_W  store data, right-aligned (bits [7:0] byte, [15:0] half).
REQ-011 SHALL have port ready_o  output  1  high only in IDLE; request accepted when req_i & ready_o.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err_o  output  1  valid with done_o; misaligned or reserved-size access.
REQ-014 SHALL have port rdata_o  output  DATA_W  extended load result, valid with done_o, held until next done_o.
REQ-015 SHALL have ports ram_we_o (output 1), ram_addr_o (output ADDR_W), ram_wdata_o (output DATA_W), ram_rdata_i (input DATA_W): word-wide RAM port; RAM read is combinational, write on clk edge.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RMW_RD, WRITE, ERR.
REQ-017 SHALL on acceptance register addr, size, unsigned, wdata; next state: error -> ERR; load -> LOAD; word store -> WRITE; byte/half store -> RMW_RD.
REQ-018 SHALL flag error when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
REQ-019 SHALL drive ram_addr_o = {registered addr[ADDR_W-1:2], 2'b00} in every non-IDLE state, and 0 in IDLE.
REQ-020 LOAD (1 cycle): SHALL capture ram_rdata_i, select lane by addr[1:0] (byte) / addr[1] (half), extend per unsigned, pulse done_o; -> IDLE. Latency: done_o 1 cycle after acceptance.
REQ-021 RMW_RD (1 cycle): SHALL capture ram_rdata_i into merge register; -> WRITE.
REQ-022 WRITE (1 cycle): SHALL assert ram_we_o=1 with ram_wdata_o = wdata (word) or captured word with only addressed lane(s) replaced; pulse done_o; -> IDLE. Latency: word store 1 cycle, sub-word store 2 cycles.
REQ-023 ERR (1 cycle): SHALL pulse done_o with err_o=1, rdata_o=0, ram_we_o=0; -> IDLE.
REQ-024 SHALL keep ram_we_o=0 outside WRITE; exactly one RAM write per accepted store.
REQ-025 SHALL ignore req_i while ready_o=0 (no queueing); back-to-back requests accepted the cycle after done_o.
REQ-026 SHALL keep err_o=0 whenever done_o=0.

Reset
REQ-027 SHALL on rst=1, immediately (asynchronously) enter IDLE; ready_o=1 once released, done_o=0, err_o=0, rdata_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
REQ-028 SHALL abort any in-flight access on reset; a reset during RMW_RD or WRITE SHALL produce no RAM write and no done_o.

Structure
REQ-029 SHALL place size encodings (SIZE_B/H/W) and FSM state encodings in the shared defines file; RST/WRITE_ENABLE/ZERO_WORD reuse existing defines.
REQ-030 SHALL isolate lane extract/merge in one combinational sub-module, ram_lane_mux.

Verification
REQ-031 RAM word 0x20000000=0x8899AABB; load byte signed addr 0x20000001 -> done_o at +1 cycle, rdata_o=0xFFFFFFAA, err_o=0.
REQ-032 Same word; store half 0x1234 at 0x20000002 -> ram_we_o only at +2 cycles, RAM word becomes 0x1234AABB, done_o at +2.
REQ-033 Store word 0xDEADBEEF at 0x20000004 -> single write at +1 cycle, readback load word = 0xDEADBEEF.
REQ-034 Load word at 0x20000006 and load half at 0x20000003 -> each done_o=1, err_o=1, rdata_o=0, no RAM write.
REQ-035 Assert rst in RMW_RD of byte store 0x55 to 0x20000000 -> ram_we_o never asserts, word unchanged, ready_o=1 after release.
REQ-036 Hold req_i high for 3 consecutive stores -> each accepted only when ready_o=1, three writes, three done_o pulses.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings for the RAM access controller: access sizes, FSM states,
// common constants and the alignment/legality check.
package ram_access_ctrl_pkg;

  localparam int WORD_W = 32;

  // Access size encodings on size_i
  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic              WRITE_ENABLE = 1'b1;
  localparam logic [WORD_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // An access is illegal when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_lane_mux.sv
// Byte-lane extract (load path) and lane merge (store path) for a 32-bit
// little-endian RAM word. Purely combinational.
module ram_lane_mux
  import ram_access_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        lo_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  src_byte  [4];
  logic [3:0]  lane_en;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sign_b;
  logic        sign_h;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = word_i[8*gi +: 8];
      // Store data is right-aligned, so a byte always comes from bits [7:0]
      // and a half supplies its low/high byte to even/odd lanes.
      assign src_byte[gi]  = (size_i == SIZE_B) ? wdata_i[7:0] :
                             (size_i == SIZE_H) ? wdata_i[8*(gi%2) +: 8] :
                                                  wdata_i[8*gi +: 8];
      assign merge_o[8*gi +: 8] = lane_en[gi] ? src_byte[gi] : byte_lane[gi];
    end
  endgenerate

  assign sel_byte = byte_lane[lo_i];
  assign sel_half = lo_i[1] ? word_i[31:16] : word_i[15:0];
  assign sign_b   = ~unsigned_i & sel_byte[7];
  assign sign_h   = ~unsigned_i & sel_half[15];

  // Right-align the addressed lane(s) and extend to a full word
  always_comb begin
    load_o = word_i;
    case (size_i)
      SIZE_B:  load_o = {{24{sign_b}}, sel_byte};
      SIZE_H:  load_o = {{16{sign_h}}, sel_half};
      default: load_o = word_i;
    endcase
  end

  // Select which byte lanes the store replaces
  always_comb begin
    lane_en = 4'b1111;
    case (size_i)
      SIZE_B:  lane_en = 4'b0001 << lo_i;
      SIZE_H:  lane_en = lo_i[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Core-to-RAM access controller: byte/half/word loads and stores on a
// word-wide RAM, with read-modify-write for sub-word stores and a one-cycle
// error completion for misaligned or reserved-size requests.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [1:0]        size_q,     size_d;
  logic              unsigned_q, unsigned_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] merge_q,    merge_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;

  logic [DATA_W-1:0] lane_word;
  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_merge;

  // In LOAD the lanes come straight from the RAM; in WRITE they come from
  // the word captured during RMW_RD.
  assign lane_word = (state_q == ST_LOAD) ? ram_rdata_i : merge_q;

  ram_lane_mux u_lane_mux (
    .word_i     (lane_word),
    .lo_i       (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  // State and request registers; reset aborts any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      wdata_q    <= ZERO_WORD;
      merge_q    <= ZERO_WORD;
      rdata_q    <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    ready_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    rdata_o     = rdata_q;
    ram_we_o    = 1'b0;
    ram_wdata_o = ZERO_WORD;
    ram_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};

    case (state_q)
      ST_IDLE: begin
        ready_o    = 1'b1;
        ram_addr_o = '0;
        if (req_i) begin
          addr_d     = addr_i;
          size_d     = size_i;
          unsigned_d = unsigned_i;
          wdata_d    = wdata_i;
          if (access_err(size_i, addr_i[1:0])) begin
            state_d = ST_ERR;
          end else if (!we_i) begin
            state_d = ST_LOAD;
          end else if (size_i == SIZE_W) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end

      ST_LOAD: begin
        done_o  = 1'b1;
        rdata_o = lane_load;
        rdata_d = lane_load;
        state_d = ST_IDLE;
      end

      ST_RMW_RD: begin
        merge_d = ram_rdata_i;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        ram_we_o    = WRITE_ENABLE;
        ram_wdata_o = (size_q == SIZE_W) ? wdata_q : lane_merge;
        done_o      = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_ERR: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        rdata_o = ZERO_WORD;
        rdata_d = ZERO_WORD;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
